// File: rtl/img_mem_pkg.sv
// img_mem_pkg
// Shared definitions for the image memory arbiter.
// Contents:
//   DEF_ADDR_W / DEF_DATA_W / DEF_MAX_WAIT : default parameter values
//   tag_e                                  : tag carried with each issued access
//   wait_cnt_w()                           : width of a counter that reaches max_wait
package img_mem_pkg;

  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_WAIT = 1024;

  // Identifies who expects the read data of an access in flight.
  // Host writes carry NONE because they return nothing.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    DISP    = 2'd1,
    HOST_RD = 2'd2
  } tag_e;

  function automatic int wait_cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/img_mem_arbiter_if.sv
// img_mem_arbiter_if
// Bundles the display, host and memory buses of the arbiter.
// Modports:
//   slave  : arbiter view (requests and MEM_RDATA in, results and MEM_* out)
//   master : requester/memory view (the opposite directions)
// Signals:
//   DISP_REQ/DISP_ADDR -> DISP_DATA/DISP_VALID          display read port
//   HOST_REQ/WE/ADDR/WDATA -> HOST_ACK/RVALID/RDATA     host access port
//   HOST_STARVED                                        host waited MAX_WAIT cycles
//   MEM_ADDR/MEM_WDATA/MEM_WE -> MEM_RDATA              single-port RAM, 1-cycle read
interface img_mem_arbiter_if
  import img_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              DISP_REQ;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic [DATA_W-1:0] DISP_DATA;
  logic              DISP_VALID;

  logic              HOST_REQ;
  logic              HOST_WE;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [DATA_W-1:0] HOST_WDATA;
  logic              HOST_ACK;
  logic              HOST_RVALID;
  logic [DATA_W-1:0] HOST_RDATA;
  logic              HOST_STARVED;

  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_WE;
  logic [DATA_W-1:0] MEM_RDATA;

  modport slave (
    input  DISP_REQ, DISP_ADDR, HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA, MEM_RDATA,
    output DISP_DATA, DISP_VALID, HOST_ACK, HOST_RVALID, HOST_RDATA, HOST_STARVED,
           MEM_ADDR, MEM_WDATA, MEM_WE
  );

  modport master (
    output DISP_REQ, DISP_ADDR, HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA, MEM_RDATA,
    input  DISP_DATA, DISP_VALID, HOST_ACK, HOST_RVALID, HOST_RDATA, HOST_STARVED,
           MEM_ADDR, MEM_WDATA, MEM_WE
  );

endinterface

// File: rtl/img_arb_starve_cnt.sv
// img_arb_starve_cnt
// Counts the cycles a host request waits without being granted and flags
// starvation once the count reaches MAX_WAIT.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   host_req     : host request level
//   host_gnt     : host granted on this edge
//   host_ack     : acknowledge cycle of the previous grant
//   host_starved : count has saturated at MAX_WAIT
module img_arb_starve_cnt
  import img_mem_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic host_req,
  input  logic host_gnt,
  input  logic host_ack,
  output logic host_starved
);

  localparam int              CNT_W   = wait_cnt_w(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // The acknowledge cycle still sees the old request held high; it has been
  // served, so it neither counts nor keeps the count alive.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!host_req || host_gnt || host_ack) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign host_starved = (wait_cnt_q == CNT_MAX);

endmodule

// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter
// Shares one single-port image RAM between a display read stream (fixed
// priority, full throughput) and a host read/write port.
// Ports:
//   CLK, RST_n     : clock, asynchronous active-low reset
//   bus (slave)    : display, host and memory buses (see img_mem_arbiter_if)
//   STAT_DISP_CNT  : granted display accesses   (IMG_ARB_STATS_EN only)
//   STAT_HOST_CNT  : granted host accesses      (IMG_ARB_STATS_EN only)
// Build option: define IMG_ARB_STATS_EN to add the access statistics counters.
module img_mem_arbiter
  import img_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                CLK,
  input  logic                RST_n,
`ifdef IMG_ARB_STATS_EN
  output logic [31:0]         STAT_DISP_CNT,
  output logic [31:0]         STAT_HOST_CNT,
`endif
  img_mem_arbiter_if.slave    bus
);

  logic              disp_gnt;
  logic              host_gnt;
  logic              host_starved;

  tag_e              tag1_q, tag1_d;
  tag_e              tag2_q, tag2_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              host_ack_q, host_ack_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  // Display always wins. The host request seen during its own acknowledge
  // cycle is the one just served, so it is not granted a second time.
  always_comb begin
    disp_gnt = bus.DISP_REQ;
    host_gnt = bus.HOST_REQ && !bus.DISP_REQ && !host_ack_q;
  end

  // Tag stage 1 lines up with the registered MEM_* signals, stage 2 with
  // MEM_RDATA; the result registers then produce the valid strobes.
  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    host_ack_d    = host_gnt;
    tag1_d        = NONE;
    if (disp_gnt) begin
      mem_addr_d = bus.DISP_ADDR;
      tag1_d     = DISP;
    end else if (host_gnt) begin
      mem_addr_d  = bus.HOST_ADDR;
      mem_wdata_d = bus.HOST_WDATA;
      mem_we_d    = bus.HOST_WE;
      tag1_d      = bus.HOST_WE ? NONE : HOST_RD;
    end
    tag2_d        = tag1_q;
    disp_valid_d  = (tag2_q == DISP);
    host_rvalid_d = (tag2_q == HOST_RD);
    disp_data_d   = disp_valid_d  ? bus.MEM_RDATA : disp_data_q;
    host_rdata_d  = host_rvalid_d ? bus.MEM_RDATA : host_rdata_q;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tag1_q        <= NONE;
      tag2_q        <= NONE;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      host_ack_q    <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_data_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      host_ack_q    <= host_ack_d;
      disp_valid_q  <= disp_valid_d;
      disp_data_q   <= disp_data_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  img_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk          (CLK),
    .rst_n        (RST_n),
    .host_req     (bus.HOST_REQ),
    .host_gnt     (host_gnt),
    .host_ack     (host_ack_q),
    .host_starved (host_starved)
  );

  assign bus.MEM_ADDR     = mem_addr_q;
  assign bus.MEM_WDATA    = mem_wdata_q;
  assign bus.MEM_WE       = mem_we_q;
  assign bus.HOST_ACK     = host_ack_q;
  assign bus.DISP_VALID   = disp_valid_q;
  assign bus.DISP_DATA    = disp_data_q;
  assign bus.HOST_RVALID  = host_rvalid_q;
  assign bus.HOST_RDATA   = host_rdata_q;
  assign bus.HOST_STARVED = host_starved;

`ifdef IMG_ARB_STATS_EN
  logic [31:0] stat_disp_cnt_q, stat_disp_cnt_d;
  logic [31:0] stat_host_cnt_q, stat_host_cnt_d;

  // Granted-access counters; they wrap naturally at 2^32.
  always_comb begin
    stat_disp_cnt_d = stat_disp_cnt_q + 32'(disp_gnt);
    stat_host_cnt_d = stat_host_cnt_q + 32'(host_gnt);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      stat_disp_cnt_q <= '0;
      stat_host_cnt_q <= '0;
    end else begin
      stat_disp_cnt_q <= stat_disp_cnt_d;
      stat_host_cnt_q <= stat_host_cnt_d;
    end
  end

  assign STAT_DISP_CNT = stat_disp_cnt_q;
  assign STAT_HOST_CNT = stat_host_cnt_q;
`else
  // Default build carries no statistics logic.
`endif

endmodule

// File: tb/tb_img_mem_arbiter.sv
// tb_img_mem_arbiter
// Directed bench for img_mem_arbiter with a small synchronous RAM model.
// Build option: IMG_ARB_STATS_EN enables the statistics checks.
module tb_img_mem_arbiter;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 8;

  logic CLK;
  logic RST_n;
  logic mem_init;
  int   tests_run;
  int   tests_failed;
  logic [DATA_W-1:0] mem [0:4095];

  img_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef IMG_ARB_STATS_EN
  logic [31:0] stat_disp_cnt;
  logic [31:0] stat_host_cnt;
`endif

  img_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
`ifdef IMG_ARB_STATS_EN
    .STAT_DISP_CNT (stat_disp_cnt),
    .STAT_HOST_CNT (stat_host_cnt),
`endif
    .bus           (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Initial RAM contents: an address-derived pattern.
  function automatic logic [DATA_W-1:0] pat(input int a);
    return DATA_W'((a * 7) + 3);
  endfunction

  // Single-port RAM, one-cycle read latency.
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else if (bus.MEM_WE) begin
      mem[bus.MEM_ADDR[11:0]] <= bus.MEM_WDATA;
    end
    bus.MEM_RDATA <= mem[bus.MEM_ADDR[11:0]];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.DISP_REQ   = 1'b0;
    bus.DISP_ADDR  = '0;
    bus.HOST_REQ   = 1'b0;
    bus.HOST_WE    = 1'b0;
    bus.HOST_ADDR  = '0;
    bus.HOST_WDATA = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_init = 1'b1;
    RST_n = 1'b1;
    #2;
    RST_n = 1'b0;
    repeat (2) tick();
    tests_run++;
    if ({bus.DISP_VALID, bus.HOST_ACK, bus.HOST_RVALID, bus.HOST_STARVED, bus.MEM_WE} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000",
               {bus.DISP_VALID, bus.HOST_ACK, bus.HOST_RVALID, bus.HOST_STARVED, bus.MEM_WE});
    end
    tests_run++;
    if ({bus.DISP_DATA, bus.HOST_RDATA, bus.MEM_WDATA} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %h expected 0", {bus.DISP_DATA, bus.HOST_RDATA, bus.MEM_WDATA});
    end
    tests_run++;
    if (bus.MEM_ADDR !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.MEM_ADDR);
    end
    mem_init = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  task automatic test_disp_stream();
    logic exp_valid;
    for (int j = 0; j < 646; j++) begin
      if (j < 640) begin
        bus.DISP_REQ  = 1'b1;
        bus.DISP_ADDR = ADDR_W'(j);
      end else begin
        bus.DISP_REQ = 1'b0;
      end
      tick();
      exp_valid = (j >= 2) && (j < 642);
      tests_run++;
      if (bus.DISP_VALID !== exp_valid) begin
        tests_failed++;
        $display("[TB] FAIL disp_stream_valid j=%0d: got %b expected %b", j, bus.DISP_VALID, exp_valid);
      end
      if (exp_valid) begin
        tests_run++;
        if (bus.DISP_DATA !== pat(j - 2)) begin
          tests_failed++;
          $display("[TB] FAIL disp_stream_data addr=%0d: got %h expected %h", j - 2, bus.DISP_DATA, pat(j - 2));
        end
      end
    end
    tests_run++;
    if (bus.DISP_DATA !== pat(639)) begin
      tests_failed++;
      $display("[TB] FAIL disp_data_hold: got %h expected %h", bus.DISP_DATA, pat(639));
    end
  endtask

  task automatic test_host_write();
    bus.HOST_REQ   = 1'b1;
    bus.HOST_WE    = 1'b1;
    bus.HOST_ADDR  = ADDR_W'(32'h100);
    bus.HOST_WDATA = 8'h5A;
    tick();
    tests_run++;
    if ({bus.HOST_ACK, bus.MEM_WE} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL host_wr_ack_we: got %b expected 11", {bus.HOST_ACK, bus.MEM_WE});
    end
    tests_run++;
    if (bus.MEM_ADDR !== ADDR_W'(32'h100) || bus.MEM_WDATA !== 8'h5A) begin
      tests_failed++;
      $display("[TB] FAIL host_wr_bus: got addr %h data %h expected addr 100 data 5a", bus.MEM_ADDR, bus.MEM_WDATA);
    end
    // Request still held through the acknowledge cycle: must not be re-granted.
    tick();
    tests_run++;
    if ({bus.HOST_ACK, bus.MEM_WE} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL host_wr_single_ack: got %b expected 00", {bus.HOST_ACK, bus.MEM_WE});
    end
    bus.HOST_REQ = 1'b0;
    bus.HOST_WE  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (bus.HOST_RVALID !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL host_wr_no_rvalid c=%0d: got %b expected 0", i, bus.HOST_RVALID);
      end
    end
  endtask

  task automatic test_host_read_contended();
    logic exp_valid;
    bus.HOST_REQ  = 1'b1;
    bus.HOST_WE   = 1'b0;
    bus.HOST_ADDR = ADDR_W'(32'h100);
    for (int i = 0; i < 5; i++) begin
      bus.DISP_REQ  = 1'b1;
      bus.DISP_ADDR = ADDR_W'(10 + i);
      tick();
      exp_valid = (i >= 2);
      tests_run++;
      if (bus.HOST_ACK !== 1'b0 || bus.DISP_VALID !== exp_valid) begin
        tests_failed++;
        $display("[TB] FAIL contend_c%0d: got ack %b dvalid %b expected ack 0 dvalid %b",
                 i, bus.HOST_ACK, bus.DISP_VALID, exp_valid);
      end
    end
    bus.DISP_REQ = 1'b0;
    tick();
    tests_run++;
    if (bus.HOST_ACK !== 1'b1 || bus.MEM_WE !== 1'b0 || bus.MEM_ADDR !== ADDR_W'(32'h100)) begin
      tests_failed++;
      $display("[TB] FAIL contend_ack: got ack %b we %b addr %h expected ack 1 we 0 addr 100",
               bus.HOST_ACK, bus.MEM_WE, bus.MEM_ADDR);
    end
    tests_run++;
    if (bus.DISP_VALID !== 1'b1 || bus.DISP_DATA !== pat(13)) begin
      tests_failed++;
      $display("[TB] FAIL contend_disp13: got %b %h expected 1 %h", bus.DISP_VALID, bus.DISP_DATA, pat(13));
    end
    bus.HOST_REQ = 1'b0;
    tick();
    tests_run++;
    if (bus.HOST_RVALID !== 1'b0 || bus.DISP_VALID !== 1'b1 || bus.DISP_DATA !== pat(14)) begin
      tests_failed++;
      $display("[TB] FAIL contend_c7: got rvalid %b dvalid %b ddata %h expected 0 1 %h",
               bus.HOST_RVALID, bus.DISP_VALID, bus.DISP_DATA, pat(14));
    end
    tick();
    tests_run++;
    if (bus.HOST_RVALID !== 1'b1 || bus.HOST_RDATA !== 8'h5A || bus.DISP_VALID !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL contend_rdata: got rvalid %b rdata %h dvalid %b expected 1 5a 0",
               bus.HOST_RVALID, bus.HOST_RDATA, bus.DISP_VALID);
    end
    tick();
    tests_run++;
    if (bus.HOST_RVALID !== 1'b0 || bus.HOST_RDATA !== 8'h5A) begin
      tests_failed++;
      $display("[TB] FAIL host_rdata_hold: got %b %h expected 0 5a", bus.HOST_RVALID, bus.HOST_RDATA);
    end
  endtask

  task automatic test_starve();
    logic exp_starved;
    bus.HOST_REQ   = 1'b1;
    bus.HOST_WE    = 1'b1;
    bus.HOST_ADDR  = ADDR_W'(32'h200);
    bus.HOST_WDATA = 8'h33;
    for (int i = 0; i < 12; i++) begin
      bus.DISP_REQ  = 1'b1;
      bus.DISP_ADDR = ADDR_W'(20 + i);
      tick();
      exp_starved = (i + 1 >= MAX_WAIT);
      tests_run++;
      if (bus.HOST_STARVED !== exp_starved || bus.HOST_ACK !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL starve_c%0d: got starved %b ack %b expected %b 0",
                 i, bus.HOST_STARVED, bus.HOST_ACK, exp_starved);
      end
    end
    bus.DISP_REQ = 1'b0;
    tick();
    tests_run++;
    if (bus.HOST_ACK !== 1'b1 || bus.HOST_STARVED !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL starve_release: got ack %b starved %b expected 1 0", bus.HOST_ACK, bus.HOST_STARVED);
    end
    bus.HOST_REQ = 1'b0;
    bus.HOST_WE  = 1'b0;
    tick();
    tests_run++;
    if (bus.HOST_STARVED !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL starve_after: got %b expected 0", bus.HOST_STARVED);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    bus.HOST_REQ   = 1'b1;
    bus.HOST_WE    = 1'b1;
    bus.HOST_ADDR  = ADDR_W'(32'h300);
    bus.HOST_WDATA = 8'hC3;
    tick();
    tests_run++;
    if (bus.HOST_ACK !== 1'b1 || bus.MEM_WE !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_wr_ack: got ack %b we %b expected 1 1", bus.HOST_ACK, bus.MEM_WE);
    end
    bus.HOST_REQ = 1'b0;
    tick();
    bus.HOST_REQ = 1'b1;
    bus.HOST_WE  = 1'b0;
    tick();
    tests_run++;
    if (bus.HOST_ACK !== 1'b1 || bus.MEM_WE !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_rd_ack: got ack %b we %b expected 1 0", bus.HOST_ACK, bus.MEM_WE);
    end
    bus.HOST_REQ = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.HOST_RVALID !== 1'b1 || bus.HOST_RDATA !== 8'hC3) begin
      tests_failed++;
      $display("[TB] FAIL b2b_rdata: got %b %h expected 1 c3", bus.HOST_RVALID, bus.HOST_RDATA);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_inflight();
    bus.DISP_REQ  = 1'b1;
    bus.DISP_ADDR = ADDR_W'(30);
    tick();
    bus.DISP_REQ = 1'b0;
    tick();
    RST_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.DISP_VALID, bus.HOST_ACK, bus.HOST_RVALID, bus.HOST_STARVED, bus.MEM_WE} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL inflight_rst_strobes: got %b expected 00000",
               {bus.DISP_VALID, bus.HOST_ACK, bus.HOST_RVALID, bus.HOST_STARVED, bus.MEM_WE});
    end
    tests_run++;
    if ({bus.DISP_DATA, bus.HOST_RDATA, bus.MEM_WDATA} !== '0 || bus.MEM_ADDR !== '0) begin
      tests_failed++;
      $display("[TB] FAIL inflight_rst_data: got %h addr %h expected 0 0",
               {bus.DISP_DATA, bus.HOST_RDATA, bus.MEM_WDATA}, bus.MEM_ADDR);
    end
    repeat (2) tick();
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (bus.DISP_VALID !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL inflight_no_valid c=%0d: got %b expected 0", i, bus.DISP_VALID);
      end
    end
  endtask

`ifdef IMG_ARB_STATS_EN
  task automatic test_stats();
    tests_run++;
    if (stat_disp_cnt !== 32'd0 || stat_host_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL stats_reset: got %0d %0d expected 0 0", stat_disp_cnt, stat_host_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      bus.DISP_REQ  = 1'b1;
      bus.DISP_ADDR = ADDR_W'(40 + i);
      tick();
    end
    bus.DISP_REQ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.HOST_REQ   = 1'b1;
      bus.HOST_WE    = 1'b1;
      bus.HOST_ADDR  = ADDR_W'(32'h400 + i);
      bus.HOST_WDATA = 8'h11;
      tick();
      bus.HOST_REQ = 1'b0;
      tick();
    end
    tests_run++;
    if (stat_disp_cnt !== 32'd3 || stat_host_cnt !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL stats_count: got %0d %0d expected 3 2", stat_disp_cnt, stat_host_cnt);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_disp_stream();
    test_host_write();
    test_host_read_contended();
    test_starve();
    test_back_to_back();
    test_reset_inflight();
`ifdef IMG_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
